// File: rtl/fll_pkg.sv
// Shared constants and helpers for the carrier FLL error and loop filter path.
// Output saturation is selected by BAND_EDGE_FLL_ERROR_SATURATE_EN.
package fll_pkg;

    localparam int DefInputLengthBits     = 12;
    localparam int DefIntegrateLengthLog2 = 4;
    localparam int DefOutputShift         = 12;
    localparam int DefOutputLengthBits    = 16;

    // Squares need 2W bits, their difference one more, N-sum adds K.
    function automatic int acc_width(input int w, input int k);
        return 2 * w + 1 + k;
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 bits
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/integrate_dump.sv
// Signed integrate-and-dump over 2^LengthLog2 valid samples with scaled output.
// BAND_EDGE_FLL_ERROR_SATURATE_EN selects clamping instead of wrap on output.
module integrate_dump
    import fll_pkg::*;
#(
    parameter int DataBits   = 25,
    parameter int LengthLog2 = 4,
    parameter int AccBits    = DataBits + LengthLog2,
    parameter int Shift      = 12,
    parameter int OutBits    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [DataBits-1:0] in_data,
    output logic signed [OutBits-1:0]  out,
    output logic                       out_valid
);

    localparam int CntBits = (LengthLog2 > 0) ? LengthLog2 : 1;
    localparam logic [CntBits-1:0] LastCount = CntBits'((1 << LengthLog2) - 1);

    logic signed [AccBits-1:0] acc;
    logic signed [AccBits-1:0] sum;
    logic signed [AccBits-1:0] shifted;
    logic signed [OutBits-1:0] fitted;
    logic [CntBits-1:0]        count;

    always_comb begin
        sum     = acc + AccBits'(in_data);
        shifted = sum >>> Shift;
`ifdef BAND_EDGE_FLL_ERROR_SATURATE_EN
        fitted  = OutBits'(saturate(64'(shifted), OutBits));
`else
        fitted  = OutBits'(shifted);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            if (count == LastCount) begin
                out       <= fitted;
                acc       <= '0;
                count     <= '0;
                out_valid <= 1'b1;
            end else begin
                acc       <= sum;
                count     <= count + 1'b1;
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/band_edge_fll_error.sv
// Band-edge FLL error: squares upper/lower FIR outputs and integrates the difference.
// BAND_EDGE_FLL_ERROR_SATURATE_EN clamps the dumped word instead of wrapping it.
module band_edge_fll_error
    import fll_pkg::*;
#(
    parameter int InputLengthBits     = DefInputLengthBits,
    parameter int IntegrateLengthLog2 = DefIntegrateLengthLog2,
    parameter int OutputShift         = DefOutputShift,
    parameter int OutputLengthBits    = DefOutputLengthBits
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic signed [InputLengthBits-1:0]  upper,
    input  logic signed [InputLengthBits-1:0]  lower,
    output logic signed [OutputLengthBits-1:0] out,
    output logic                               out_valid
);

    localparam int W = InputLengthBits;

    logic signed [2*W-1:0] prod_u;
    logic signed [2*W-1:0] prod_l;
    logic [2*W-1:0]        sq_u;
    logic [2*W-1:0]        sq_l;
    logic                  v1;
    logic signed [2*W:0]   diff;
    logic                  v2;

    // Operands widen to 2W before multiply, so -2^(W-1) squared is exact.
    always_comb begin
        prod_u = (2*W)'(upper) * (2*W)'(upper);
        prod_l = (2*W)'(lower) * (2*W)'(lower);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_u <= '0;
            sq_l <= '0;
            v1   <= 1'b0;
            diff <= '0;
            v2   <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                sq_u <= $unsigned(prod_u);
                sq_l <= $unsigned(prod_l);
            end
            v2 <= v1;
            if (v1) begin
                diff <= $signed({1'b0, sq_u}) - $signed({1'b0, sq_l});
            end
        end
    end

    integrate_dump #(
        .DataBits   (2 * W + 1),
        .LengthLog2 (IntegrateLengthLog2),
        .AccBits    (acc_width(W, IntegrateLengthLog2)),
        .Shift      (OutputShift),
        .OutBits    (OutputLengthBits)
    ) u_integrate_dump (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .in_data   (diff),
        .out       (out),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_band_edge_fll_error.sv
// Self-checking bench for band_edge_fll_error (shift 12 and shift 8 instances).
// Expected words follow BAND_EDGE_FLL_ERROR_SATURATE_EN the same way as the design.
module tb_band_edge_fll_error;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [11:0] upper = '0;
    logic signed [11:0] lower = '0;
    logic signed [15:0] out_a;
    logic               out_valid_a;
    logic signed [15:0] out_b;
    logic               out_valid_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int     due;
        longint sum;
    } dump_t;

    dump_t       pending[$];
    longint      m_sum = 0;
    int          m_cnt = 0;
    logic [15:0] held_a = '0;
    logic [15:0] held_b = '0;

    band_edge_fll_error u_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .upper     (upper),
        .lower     (lower),
        .out       (out_a),
        .out_valid (out_valid_a)
    );

    band_edge_fll_error #(.OutputShift(8)) u_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .upper     (upper),
        .lower     (lower),
        .out       (out_b),
        .out_valid (out_valid_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] fit(input longint s, input int sh);
        longint x;
        x = s >>> sh;
`ifdef BAND_EDGE_FLL_ERROR_SATURATE_EN
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
`endif
        return x[15:0];
    endfunction

    task automatic check_outputs();
        logic exp_v;
        exp_v = 1'b0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            exp_v  = 1'b1;
            held_a = fit(pending[0].sum, 12);
            held_b = fit(pending[0].sum, 8);
            void'(pending.pop_front());
        end
        tests++;
        assert (out_valid_a === exp_v) else begin
            fails++;
            $error("FAIL valid_a cyc=%0d got=%b exp=%b", cyc, out_valid_a, exp_v);
        end
        tests++;
        assert (out_a === held_a) else begin
            fails++;
            $error("FAIL out_a cyc=%0d got=%0d exp=%0d", cyc, out_a, $signed(held_a));
        end
        tests++;
        assert (out_valid_b === exp_v) else begin
            fails++;
            $error("FAIL valid_b cyc=%0d got=%b exp=%b", cyc, out_valid_b, exp_v);
        end
        tests++;
        assert (out_b === held_b) else begin
            fails++;
            $error("FAIL out_b cyc=%0d got=%0d exp=%0d", cyc, out_b, $signed(held_b));
        end
    endtask

    // Pair driven now is taken at the next edge; its dump shows 3 edges later.
    task automatic step(input logic v, input int u, input int l, input logic r);
        dump_t d;
        @(negedge clk);
        check_outputs();
        rst      = r;
        in_valid = v;
        upper    = 12'(u);
        lower    = 12'(l);
        if (r) begin
            pending.delete();
            m_sum  = 0;
            m_cnt  = 0;
            held_a = '0;
            held_b = '0;
        end else if (v) begin
            m_sum += longint'(u) * u - longint'(l) * l;
            m_cnt++;
            if (m_cnt == 16) begin
                d.due = cyc + 3;
                d.sum = m_sum;
                pending.push_back(d);
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom_range(4095) - 2048, $urandom_range(4095) - 2048, 1'b0);
    endtask

    task automatic window(input int n, input int u, input int l);
        for (int i = 0; i < n; i++) step(1'b1, u, l, 1'b0);
    endtask

    task automatic expect_a(input string tag, input logic signed [15:0] e);
        tests++;
        assert (out_a === e) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, out_a, e);
        end
    endtask

    initial begin
        for (int i = 0; i < 100; i++) step(1'b1, 1000, -500, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        idle(2);

        window(16, 100, 0);
        idle(5);
        expect_a("pos_error", 16'sd39);

        window(16, 0, 100);
        idle(5);
        expect_a("neg_error", -16'sd40);

        window(16, -700, -700);
        idle(5);
        expect_a("balanced", 16'sd0);

        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(3));
            step(1'b1, 100, 0, 1'b0);
        end
        idle(5);
        expect_a("gapped", 16'sd39);

        window(16, -2048, 0);
        idle(5);
        expect_a("big_shift12", 16'sd16384);
        tests++;
`ifdef BAND_EDGE_FLL_ERROR_SATURATE_EN
        assert (out_b === 16'sd32767) else begin
            fails++;
            $error("FAIL sat_b got=%0d exp=32767", out_b);
        end
`else
        assert (out_b === 16'sd0) else begin
            fails++;
            $error("FAIL wrap_b got=%0d exp=0", out_b);
        end
`endif

        window(10, 100, 0);
        step(1'b1, 100, 0, 1'b1);
        window(16, 100, 0);
        idle(5);
        expect_a("reset_mid", 16'sd39);

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(3) != 0,
                 $urandom_range(4095) - 2048,
                 $urandom_range(4095) - 2048, 1'b0);
        end
        window(16, -2048, 2047);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
